clock_ctrl: RTL and testbench

Parametrised CPU clock controller that replaces the fixed free-running divider between the board oscillator and the CPU clock. It generates the slow CPU clock with a runtime-programmable divide ratio. It also adds single-step execution from a debounced push-button and an address breakpoint that halts the CPU clock, and it counts CPU cycles for the hex displays.

---
 rtl/clock_ctrl.sv | 149 ++++++++++++++
 tb/tb_clock_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// CPU clock controller: programmable divider, debounced single-step,
// address breakpoint halt and CPU cycle counter.
module clock_ctrl #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEBOUNCE   = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  step_btn,
  input  logic [WIDTH-1:0]      div,
  input  logic                  bp_en,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  output logic                  clk_out,
  output logic                  halted,
  output logic [31:0]           cycle_count
);

  localparam int DBW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP_HI,
    STEP_LO
  } state_t;

  logic           r_run_s1, r_run_s2, r_run_q;
  logic           r_btn_s1, r_btn_s2, r_btn_db, r_btn_q;
  logic [DBW-1:0] r_db_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
      r_run_q  <= 1'b0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_btn_db <= 1'b1;
      r_btn_q  <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_run_s1 <= run;
      r_run_s2 <= r_run_s1;
      r_run_q  <= r_run_s2;
      r_btn_s1 <= step_btn;
      r_btn_s2 <= r_btn_s1;
      r_btn_q  <= r_btn_db;
      // debounced level follows only after a long enough disagreement
      if (r_btn_s2 != r_btn_db) begin
        if (r_db_cnt == DBW'(DEBOUNCE - 1)) begin
          r_btn_db <= r_btn_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  logic w_run_rise, w_step_press;
  assign w_run_rise   = r_run_s2 & ~r_run_q;
  assign w_step_press = r_btn_q & ~r_btn_db;

  state_t           r_state, w_state_nx;
  logic             r_clk, w_clk_nx;
  logic [WIDTH-1:0] r_hc, w_hc_nx;
  logic [WIDTH-1:0] r_d, w_dsel;
  logic             r_skip, w_skip_nx;
  logic             r_halted;
  logic [31:0]      r_count;
  logic             w_tick, w_hit, w_rise;

  assign w_dsel = (div == '0) ? WIDTH'(1) : div;
  assign w_tick = (r_state != IDLE) && (r_hc == r_d - WIDTH'(1));
  assign w_hit  = bp_en && (cpu_address == bp_addr) && !r_skip;
  assign w_rise = ~r_clk & w_clk_nx;

  always_comb begin
    w_state_nx = r_state;
    w_clk_nx   = r_clk;
    w_skip_nx  = r_skip;
    w_hc_nx    = w_tick ? '0 : r_hc + WIDTH'(1);
    unique case (r_state)
      IDLE: begin
        w_clk_nx = 1'b0;
        w_hc_nx  = '0;
        if (w_run_rise) begin
          w_state_nx = RUN;
          w_skip_nx  = 1'b1;
        end else if (w_step_press) begin
          w_state_nx = STEP_HI;
          w_clk_nx   = 1'b1;
        end
      end
      RUN: begin
        if (w_tick) begin
          if (r_clk) begin
            w_clk_nx = 1'b0;
          end else if (!r_run_s2 || w_hit) begin
            w_state_nx = IDLE;
          end else begin
            w_clk_nx  = 1'b1;
            w_skip_nx = 1'b0;
          end
        end
      end
      STEP_HI: begin
        if (w_tick) begin
          w_state_nx = STEP_LO;
          w_clk_nx   = 1'b0;
        end
      end
      STEP_LO: begin
        if (w_tick) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_clk    <= 1'b0;
      r_hc     <= '0;
      r_d      <= WIDTH'(1);
      r_skip   <= 1'b0;
      r_halted <= 1'b1;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_clk    <= w_clk_nx;
      r_hc     <= w_hc_nx;
      r_skip   <= w_skip_nx;
      r_halted <= (w_state_nx == IDLE);
      if (r_state == IDLE || w_tick) r_d <= w_dsel;
      if (w_rise) r_count <= r_count + 32'd1;
    end
  end

  assign clk_out     = r_clk;
  assign halted      = r_halted;
  assign cycle_count = r_count;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: free-run, div change, stop, step,
// breakpoint, resume and asynchronous reset.
module tb_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b1;
  logic        step_btn = 1'b1;
  logic [31:0] div = 32'd3;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = 16'h0010;
  logic [15:0] cpu_address = 16'h000E;
  logic        clk_out;
  logic        halted;
  logic [31:0] cycle_count;

  int n_pass = 0;
  int n_total = 0;

  clock_ctrl #(
    .WIDTH(32),
    .ADDR_WIDTH(16),
    .DEBOUNCE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .step_btn(step_btn),
    .div(div),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .cpu_address(cpu_address),
    .clk_out(clk_out),
    .halted(halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // reset with run high, div=3
    cyc(3);
    chk("rst_clk", {31'd0, clk_out}, 32'd0);
    chk("rst_halt", {31'd0, halted}, 32'd1);
    chk("rst_cnt", cycle_count, 32'd0);
    rst = 1'b1;
    cyc(3);
    chk("run_halt_lo", {31'd0, halted}, 32'd0);
    cyc(2);
    chk("c5_low", {31'd0, clk_out}, 32'd0);
    cyc(1);
    chk("c6_rise", {31'd0, clk_out}, 32'd1);
    chk("c6_cnt", cycle_count, 32'd1);
    cyc(3);
    chk("c9_fall", {31'd0, clk_out}, 32'd0);
    cyc(3);
    chk("c12_rise", {31'd0, clk_out}, 32'd1);
    cyc(12);
    chk("c24_hi", {31'd0, clk_out}, 32'd1);
    chk("c24_cnt4", cycle_count, 32'd4);

    // div=0 applies at next reload, then period 2
    div = 32'd0;
    cyc(2);
    chk("d0_hold_hi", {31'd0, clk_out}, 32'd1);
    cyc(1);
    chk("d0_c27", {31'd0, clk_out}, 32'd0);
    cyc(1);
    chk("d0_c28", {31'd0, clk_out}, 32'd1);
    chk("d0_cnt5", cycle_count, 32'd5);
    cyc(1);
    chk("d0_c29", {31'd0, clk_out}, 32'd0);
    cyc(1);
    chk("d0_c30", {31'd0, clk_out}, 32'd1);
    chk("d0_cnt6", cycle_count, 32'd6);

    // div=5, drop run in the high phase
    div = 32'd5;
    cyc(1);
    chk("d5_c31", {31'd0, clk_out}, 32'd0);
    cyc(5);
    chk("d5_c36", {31'd0, clk_out}, 32'd1);
    chk("d5_cnt7", cycle_count, 32'd7);
    cyc(1);
    run = 1'b0;
    cyc(3);
    chk("stop_hi_kept", {31'd0, clk_out}, 32'd1);
    cyc(1);
    chk("stop_fall", {31'd0, clk_out}, 32'd0);
    cyc(4);
    chk("stop_not_yet", {31'd0, halted}, 32'd0);
    cyc(1);
    chk("stop_halted", {31'd0, halted}, 32'd1);
    cyc(10);
    chk("stop_no_rise", {31'd0, clk_out}, 32'd0);
    chk("stop_cnt", cycle_count, 32'd7);

    // step press with bounce, div=2
    div = 32'd2;
    step_btn = 1'b0; cyc(1);
    step_btn = 1'b1; cyc(1);
    step_btn = 1'b0; cyc(1);
    step_btn = 1'b1; cyc(1);
    step_btn = 1'b0;
    cyc(6);
    chk("st_pre", {31'd0, clk_out}, 32'd0);
    chk("st_pre_halt", {31'd0, halted}, 32'd1);
    cyc(1);
    chk("st_rise", {31'd0, clk_out}, 32'd1);
    chk("st_run_halt", {31'd0, halted}, 32'd0);
    chk("st_cnt8", cycle_count, 32'd8);
    cyc(1);
    chk("st_hi2", {31'd0, clk_out}, 32'd1);
    cyc(1);
    chk("st_lo1", {31'd0, clk_out}, 32'd0);
    cyc(1);
    chk("st_lo2_halt", {31'd0, halted}, 32'd0);
    cyc(1);
    chk("st_end_halt", {31'd0, halted}, 32'd1);
    step_btn = 1'b1;
    cyc(10);
    chk("st_one_pulse", cycle_count, 32'd8);

    // breakpoint at 0x0010
    bp_en = 1'b1;
    run = 1'b1;
    cyc(5);
    chk("bp_r1", {31'd0, clk_out}, 32'd1);
    chk("bp_cnt9", cycle_count, 32'd9);
    cpu_address = 16'h000F;
    cyc(4);
    chk("bp_r2", cycle_count, 32'd10);
    cpu_address = 16'h0010;
    cyc(2);
    chk("bp_fall", {31'd0, clk_out}, 32'd0);
    chk("bp_run", {31'd0, halted}, 32'd0);
    cyc(2);
    chk("bp_halted", {31'd0, halted}, 32'd1);
    cyc(6);
    chk("bp_held_lo", {31'd0, clk_out}, 32'd0);
    chk("bp_cnt_hold", cycle_count, 32'd10);

    // single step from the breakpoint
    step_btn = 1'b0;
    cyc(7);
    chk("bp_st_rise", {31'd0, clk_out}, 32'd1);
    chk("bp_st_cnt", cycle_count, 32'd11);
    step_btn = 1'b1;
    cyc(4);
    chk("bp_st_halt", {31'd0, halted}, 32'd1);
    cyc(8);
    chk("bp_st_once", cycle_count, 32'd11);

    // re-toggle run: first rise skips the breakpoint
    run = 1'b0;
    cyc(4);
    run = 1'b1;
    cyc(5);
    chk("rs_rise", {31'd0, clk_out}, 32'd1);
    chk("rs_cnt12", cycle_count, 32'd12);
    chk("rs_run", {31'd0, halted}, 32'd0);
    cpu_address = 16'h0011;
    cyc(4);
    chk("rs_cnt13", cycle_count, 32'd13);
    run = 1'b0;
    cyc(12);
    chk("rs_stop", {31'd0, halted}, 32'd1);

    // async reset during STEP_HI
    step_btn = 1'b0;
    cyc(7);
    chk("ar_hi", {31'd0, clk_out}, 32'd1);
    chk("ar_cnt14", cycle_count, 32'd14);
    #1 rst = 1'b0;
    #1;
    chk("ar_clk", {31'd0, clk_out}, 32'd0);
    chk("ar_halt", {31'd0, halted}, 32'd1);
    chk("ar_cnt", cycle_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
